sap_controller: RTL

Controller/sequencer for the SAP datapath. It is the stage directly upstream of the program counter and drives its increment and output enable. It runs a one-hot T-state ring counter and decodes the 4-bit opcode from the instruction register into the full control word for the bus. Each instruction takes one fetch phase (T1–T3) and one execute phase (T4–T6). `halt` latches on HLT.

---
 rtl/sap_controller.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/sap_controller.sv
// SAP controller: one-hot T1..T6 ring counter plus opcode decode into the bus control word.
// Latency: control word is combinational from tstate/opcode; tstate advances one step per clk edge.
// Backpressure: none; the ring freezes at T4 once HLT latches halt, and only low_clr releases it.
// Optional build macro SAP_VARLEN_EN: each instruction returns to T1 right after its last useful T-state.

module sap_controller (
  input  logic       clk,
  input  logic       low_clr,
  input  logic [3:0] opcode,
  output logic       low_pc_inc,
  output logic       pc_out_en,
  output logic       low_mar_in,
  output logic       low_ram_out,
  output logic       low_ir_in,
  output logic       ir_out_en,
  output logic       low_a_in,
  output logic       a_out_en,
  output logic       alu_sub,
  output logic       alu_out_en,
  output logic       low_b_in,
  output logic       low_out_in,
  output logic       halt,
  output logic [5:0] tstate
);

  // One-hot T-states
  localparam logic [5:0] T1 = 6'b000001;
  localparam logic [5:0] T2 = 6'b000010;
  localparam logic [5:0] T3 = 6'b000100;
  localparam logic [5:0] T4 = 6'b001000;
  localparam logic [5:0] T5 = 6'b010000;
  localparam logic [5:0] T6 = 6'b100000;

  // Opcode map
  localparam logic [3:0] OP_LDA = 4'b0000;
  localparam logic [3:0] OP_ADD = 4'b0001;
  localparam logic [3:0] OP_SUB = 4'b0010;
  localparam logic [3:0] OP_OUT = 4'b1110;
  localparam logic [3:0] OP_HLT = 4'b1111;

  logic [5:0] tstate_q, tstate_d;
  logic       halt_q, halt_d;

`ifdef SAP_VARLEN_EN
  logic [5:0] last_t;

  // Last useful T-state of the current instruction; the ring returns to T1 after it.
  always_comb begin
    last_t = T6;
    case (opcode)
      OP_LDA:         last_t = T5;
      OP_ADD, OP_SUB: last_t = T6;
      OP_OUT:         last_t = T4;
      OP_HLT:         last_t = T6;
      default:        last_t = T3;
    endcase
  end
`endif

  // Ring counter next state and sticky halt; HLT in T4 freezes the ring where it is.
  always_comb begin
    tstate_d = {tstate_q[4:0], tstate_q[5]};
    halt_d   = halt_q;
    if (halt_q) begin
      tstate_d = tstate_q;
    end else if ((tstate_q == T4) && (opcode == OP_HLT)) begin
      halt_d   = 1'b1;
      tstate_d = tstate_q;
    end
`ifdef SAP_VARLEN_EN
    else if (tstate_q == last_t) begin
      tstate_d = T1;
    end
`endif
  end

  // State registers; reset aborts any instruction and returns to T1.
  always_ff @(posedge clk or negedge low_clr) begin
    if (!low_clr) begin
      tstate_q <= T1;
      halt_q   <= 1'b0;
    end else begin
      tstate_q <= tstate_d;
      halt_q   <= halt_d;
    end
  end

  // Control word decode; everything inactive by default and forced inactive while halted.
  always_comb begin
    low_pc_inc  = 1'b1;
    pc_out_en   = 1'b0;
    low_mar_in  = 1'b1;
    low_ram_out = 1'b1;
    low_ir_in   = 1'b1;
    ir_out_en   = 1'b0;
    low_a_in    = 1'b1;
    a_out_en    = 1'b0;
    alu_sub     = 1'b0;
    alu_out_en  = 1'b0;
    low_b_in    = 1'b1;
    low_out_in  = 1'b1;
    if (!halt_q) begin
      case (tstate_q)
        T1: begin
          pc_out_en  = 1'b1;
          low_mar_in = 1'b0;
        end
        T2: low_pc_inc = 1'b0;
        T3: begin
          low_ram_out = 1'b0;
          low_ir_in   = 1'b0;
        end
        T4: begin
          case (opcode)
            OP_LDA, OP_ADD, OP_SUB: begin
              ir_out_en  = 1'b1;
              low_mar_in = 1'b0;
            end
            OP_OUT: begin
              a_out_en   = 1'b1;
              low_out_in = 1'b0;
            end
            default: ;
          endcase
        end
        T5: begin
          case (opcode)
            OP_LDA: begin
              low_ram_out = 1'b0;
              low_a_in    = 1'b0;
            end
            OP_ADD, OP_SUB: begin
              low_ram_out = 1'b0;
              low_b_in    = 1'b0;
            end
            default: ;
          endcase
        end
        T6: begin
          if ((opcode == OP_ADD) || (opcode == OP_SUB)) begin
            alu_out_en = 1'b1;
            low_a_in   = 1'b0;
            alu_sub    = (opcode == OP_SUB);
          end
        end
        default: ;
      endcase
    end
  end

  assign tstate = tstate_q;
  assign halt   = halt_q;

endmodule
